bp_update_ctrl: RTL and testbench

//  Sequences branch-resolution updates into the bp_cache write port.
//  - Resolved branches (pc, taken) enter a small FIFO.
//  - Each entry does a read-modify-write on its 2-bit saturating counter:

---
 rtl/bp_update_ctrl.sv | 146 ++++++++++++++
 tb/tb_bp_update_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl.sv
// Branch-predictor update sequencer.
// Buffers resolved branches in a small FIFO and performs a read-modify-write
// of each branch's 2-bit saturating counter through bp_cache read port 1 and
// the bp_cache write port. One update completes every two cycles.
module bp_update_ctrl #(
    parameter int unsigned AWIDTH = 30,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [AWIDTH-1:0] upd_pc,
    input  logic              upd_taken,
    output logic [AWIDTH-1:0] ra1,
    input  logic [1:0]        dout1,
    input  logic              hit1,
    output logic [AWIDTH-1:0] wa,
    output logic [1:0]        din,
    output logic              we,
    output logic              busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;

    logic [AWIDTH-1:0] r_fifo_pc [DEPTH];
    logic [DEPTH-1:0]  r_fifo_taken;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [AWIDTH-1:0] r_entry_pc;
    logic              r_entry_taken;
    logic [1:0]        r_cnt;
    logic [1:0]        w_cnt_next;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign upd_ready = !w_full;
    assign w_push    = upd_valid && !w_full;
    // The head is consumed whenever the FSM is ready to start a new RMW.
    assign w_pop     = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_WRITE));

    // FIFO storage: data only, validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= upd_pc;
            r_fifo_taken[r_wr_ptr] <= upd_taken;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // New counter value: saturating step on hit, weak-state allocate on miss.
    always_comb begin
        w_cnt_next = 2'b00;
        if (hit1) begin
            if (r_entry_taken) begin
                w_cnt_next = (dout1 == 2'b11) ? 2'b11 : dout1 + 2'd1;
            end else begin
                w_cnt_next = (dout1 == 2'b00) ? 2'b00 : dout1 - 2'd1;
            end
        end else begin
            w_cnt_next = r_entry_taken ? 2'b10 : 2'b01;
        end
    end

    // FSM next-state: IDLE -> LOOKUP -> WRITE -> (LOOKUP | IDLE).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   w_state_next = w_empty ? ST_IDLE : ST_LOOKUP;
            ST_LOOKUP: w_state_next = ST_WRITE;
            ST_WRITE:  w_state_next = w_empty ? ST_IDLE : ST_LOOKUP;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // State, latched entry and computed counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_entry_pc    <= '0;
            r_entry_taken <= 1'b0;
            r_cnt         <= 2'b00;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_entry_pc    <= r_fifo_pc[r_rd_ptr];
                r_entry_taken <= r_fifo_taken[r_rd_ptr];
            end
            if (r_state == ST_LOOKUP) begin
                r_cnt <= w_cnt_next;
            end
        end
    end

    // Cache-port outputs decode straight from state so reset kills a write at once.
    always_comb begin
        ra1  = '0;
        wa   = '0;
        din  = 2'b00;
        we   = 1'b0;
        if (r_state == ST_LOOKUP) begin
            ra1 = r_entry_pc;
        end
        if (r_state == ST_WRITE) begin
            we  = 1'b1;
            wa  = r_entry_pc;
            din = r_cnt;
        end
        busy = !w_empty || (r_state != ST_IDLE);
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl: a direct-mapped cache model feeds
// read port 1, and a pc-keyed reference table predicts every write.
module tb_bp_update_ctrl;

    localparam int unsigned AW    = 30;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = 4;
    localparam int unsigned NLINE = 16;

    localparam logic [AW-1:0] PC_A = 30'h15555557;
    localparam logic [AW-1:0] PC_B = 30'h35555557;
    localparam logic [AW-1:0] PC_S = 30'h00000012;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic          taken;
    } upd_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic [AW-1:0] upd_pc = '0;
    logic          upd_taken = 1'b0;
    logic [AW-1:0] ra1;
    logic [1:0]    dout1;
    logic          hit1;
    logic [AW-1:0] wa;
    logic [1:0]    din;
    logic          we;
    logic          busy;

    int n_tests = 0;
    int n_fail = 0;
    int n_accepted = 0;
    int n_writes = 0;
    int cyc = 0;
    int last_cyc = 0;
    bit have_prev = 0;
    bit prev_we = 0;
    bit chk_b2b = 0;
    bit saw_full = 0;
    logic c_clear = 1'b1;

    upd_t          exp_q[$];
    logic [1:0]    din_log[$];
    logic [AW-1:0] ref_pc[int];
    int            ref_cnt[int];

    // Cache model arrays
    logic          c_valid[NLINE];
    logic [AW-1:0] c_pc[NLINE];
    logic [1:0]    c_data[NLINE];

    bp_update_ctrl #(
        .AWIDTH(AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .upd_valid(upd_valid),
        .upd_ready(upd_ready),
        .upd_pc   (upd_pc),
        .upd_taken(upd_taken),
        .ra1      (ra1),
        .dout1    (dout1),
        .hit1     (hit1),
        .wa       (wa),
        .din      (din),
        .we       (we),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    assign hit1  = c_valid[ra1[IW-1:0]] && (c_pc[ra1[IW-1:0]] == ra1);
    assign dout1 = c_data[ra1[IW-1:0]];

    // Direct-mapped cache: a write overwrites tag and data of its line.
    always @(posedge clk) begin
        if (c_clear) begin
            for (int i = 0; i < NLINE; i++) begin
                c_valid[i] <= 1'b0;
                c_pc[i]    <= '0;
                c_data[i]  <= 2'b00;
            end
        end else if (we) begin
            c_valid[wa[IW-1:0]] <= 1'b1;
            c_pc[wa[IW-1:0]]    <= wa;
            c_data[wa[IW-1:0]]  <= din;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: each write must be the oldest accepted update, with the
    // counter predicted from the reference table.
    upd_t m_u;
    int   m_idx;
    int   m_exp;
    always @(negedge clk) begin
        if (reset) begin
            prev_we = 0;
        end else begin
            if (we) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", 32'(we), 32'(0));
                end else begin
                    m_u   = exp_q.pop_front();
                    m_idx = int'(m_u.pc[IW-1:0]);
                    if (ref_pc.exists(m_idx) && ref_pc[m_idx] == m_u.pc) begin
                        if (m_u.taken) m_exp = (ref_cnt[m_idx] == 3) ? 3 : ref_cnt[m_idx] + 1;
                        else           m_exp = (ref_cnt[m_idx] == 0) ? 0 : ref_cnt[m_idx] - 1;
                    end else begin
                        m_exp = m_u.taken ? 2 : 1;
                    end
                    check("wr_addr", 32'(wa), 32'(m_u.pc));
                    check("wr_data", 32'(din), 32'(m_exp));
                    ref_pc[m_idx]  = m_u.pc;
                    ref_cnt[m_idx] = m_exp;
                end
                din_log.push_back(din);
                n_writes++;
                if (prev_we) check("we_consecutive", 32'(prev_we), 32'(0));
                if (chk_b2b && have_prev) check("b2b_spacing", 32'(cyc - last_cyc), 32'(2));
                last_cyc  = cyc;
                have_prev = 1;
            end else begin
                check("wa_idle", 32'(wa), 32'(0));
                check("din_idle", 32'(din), 32'(0));
            end
            prev_we = we;
        end
    end

    task automatic push(input logic [AW-1:0] pc, input logic t);
        int guard;
        guard = 0;
        @(negedge clk);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = t;
        while (!upd_ready && guard < 50) begin
            saw_full = 1;
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("push_timeout", 32'(upd_ready), 32'(1));
        @(posedge clk);
        exp_q.push_back('{pc: pc, taken: t});
        n_accepted++;
        #1 upd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        logic [AW-1:0] rpc;

        // Reset held for 5 cycles
        repeat (5) @(posedge clk);
        #1;
        check("rst_we", 32'(we), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ready", 32'(upd_ready), 32'(1));
        check("rst_ra1", 32'(ra1), 32'(0));
        check("rst_wa", 32'(wa), 32'(0));
        check("rst_din", 32'(din), 32'(0));
        c_clear = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Miss allocate with latency: push edge k, LOOKUP after k+1, write after k+2
        din_log.delete();
        push(PC_A, 1'b1);
        check("lat_busy", 32'(busy), 32'(1));
        check("lat_ra1_idle", 32'(ra1), 32'(0));
        @(posedge clk); #1;
        check("lat_lookup_ra1", 32'(ra1), 32'(PC_A));
        check("lat_lookup_we", 32'(we), 32'(0));
        @(posedge clk); #1;
        check("lat_write_we", 32'(we), 32'(1));
        check("lat_write_wa", 32'(wa), 32'(PC_A));
        check("lat_write_din", 32'(din), 32'(2'b10));
        drain();
        check("alloc_nwr", 32'(din_log.size()), 32'(1));

        // Saturation up then down
        din_log.delete();
        repeat (3) push(PC_S, 1'b1);
        drain();
        check("sat_up_n", 32'(din_log.size()), 32'(3));
        check("sat_up_0", 32'(din_log[0]), 32'(2'b10));
        check("sat_up_1", 32'(din_log[1]), 32'(2'b11));
        check("sat_up_2", 32'(din_log[2]), 32'(2'b11));
        din_log.delete();
        repeat (4) push(PC_S, 1'b0);
        drain();
        check("sat_dn_n", 32'(din_log.size()), 32'(4));
        check("sat_dn_0", 32'(din_log[0]), 32'(2'b10));
        check("sat_dn_1", 32'(din_log[1]), 32'(2'b01));
        check("sat_dn_2", 32'(din_log[2]), 32'(2'b00));
        check("sat_dn_3", 32'(din_log[3]), 32'(2'b00));

        // Eviction: A (hit, 10->11), B same index (miss, 01), A again (miss, 01)
        din_log.delete();
        push(PC_A, 1'b1);
        push(PC_B, 1'b0);
        push(PC_A, 1'b0);
        drain();
        check("evict_n", 32'(din_log.size()), 32'(3));
        check("evict_0", 32'(din_log[0]), 32'(2'b11));
        check("evict_1", 32'(din_log[1]), 32'(2'b01));
        check("evict_2", 32'(din_log[2]), 32'(2'b01));

        // Back-to-back burst that fills the FIFO
        chk_b2b   = 1;
        have_prev = 0;
        saw_full  = 0;
        for (int i = 0; i < 12; i++) begin
            push({26'($urandom_range(0, 2)), 4'($urandom_range(0, 3))}, 1'($urandom));
        end
        drain();
        chk_b2b = 0;
        check("burst_saw_full", 32'(saw_full), 32'(1));
        check("burst_no_loss", 32'(exp_q.size()), 32'(0));

        // Randomized updates with random gaps
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rpc = {26'($urandom_range(0, 2)), 4'($urandom_range(0, 5))};
            push(rpc, 1'($urandom));
        end
        drain();
        check("rand_no_loss", 32'(exp_q.size()), 32'(0));
        check("writes_eq_accepted", 32'(n_writes), 32'(n_accepted));

        // Reset asserted in the middle of a WRITE
        push(PC_S, 1'b1);
        push(PC_B, 1'b1);
        guard = 0;
        @(negedge clk);
        while (!we && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("mid_we_seen", 32'(we), 32'(1));
        reset = 1'b1;
        #1;
        check("mid_rst_we", 32'(we), 32'(0));
        check("mid_rst_wa", 32'(wa), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_ready", 32'(upd_ready), 32'(1));
        c_clear = 1'b1;
        exp_q.delete();
        ref_pc.delete();
        ref_cnt.delete();
        repeat (2) @(posedge clk);
        c_clear = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Operation after reset starts from an empty cache
        din_log.delete();
        push(PC_A, 1'b0);
        drain();
        check("post_rst_n", 32'(din_log.size()), 32'(1));
        check("post_rst_din", 32'(din_log[0]), 32'(2'b01));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
